// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Single-word req/ack memory handshake controller feeding the fetch
//            unit; flags misaligned accesses. Optional REQ timeout is built
//            when MEM_TIMEOUT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              pReq,
    input  logic              pWe,
    input  logic [ADDR_W-1:0] pAddr,
    input  logic [DATA_W-1:0] pWData,
    output logic [DATA_W-1:0] pOutMemData,
    output logic              pDataValid,
    output logic              pBusy,
    output logic              pErr,
    output logic              pMemReq,
    output logic              pMemWe,
    output logic [ADDR_W-1:0] pMemAddr,
    output logic [DATA_W-1:0] pMemWData,
    input  logic              pMemAck,
    input  logic [DATA_W-1:0] pMemRData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              memreq_q, valid_q, err_q, busy_q;
    logic              timeout_w;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Fires in the last allowed REQ cycle; an ack in that cycle still wins.
    assign timeout_w = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pReq) begin
                    if (pAddr[1:0] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_REQ;
                        addr_d  = pAddr;
                        we_d    = pWe;
                        wdata_d = pWData;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            S_REQ: begin
                if (pMemAck) begin
                    state_d = S_DONE;
                    we_d    = 1'b0;
                    if (!we_q) rdata_d = pMemRData;
                end else if (timeout_w) begin
                    state_d = S_ERR;
                    we_d    = 1'b0;
                end else begin
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they align with it.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            state_q  <= S_IDLE;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            memreq_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            memreq_q <= (state_d == S_REQ);
            valid_q  <= (state_d == S_DONE);
            err_q    <= (state_d == S_ERR);
            busy_q   <= (state_d != S_IDLE);
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign pOutMemData = rdata_q;
    assign pDataValid  = valid_q;
    assign pBusy       = busy_q;
    assign pErr        = err_q;
    assign pMemReq     = memreq_q;
    assign pMemWe      = we_q;
    assign pMemAddr    = addr_q;
    assign pMemWData   = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Directed plus randomized bench for mem_access_ctrl against a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst, req, we, ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic [DW-1:0] o_out, o_waddr_dummy;
    logic          o_valid, o_busy, o_err, o_mreq, o_mwe;
    logic [AW-1:0] o_maddr;
    logic [DW-1:0] o_mwdata;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    // Reference model: expected outputs derived from the transaction rules
    logic          m_req, m_we, m_valid, m_err, m_busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_out;
    int            m_wait;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pClk(clk), .pReset(rst), .pReq(req), .pWe(we), .pAddr(addr), .pWData(wdata),
        .pOutMemData(o_out), .pDataValid(o_valid), .pBusy(o_busy), .pErr(o_err),
        .pMemReq(o_mreq), .pMemWe(o_mwe), .pMemAddr(o_maddr), .pMemWData(o_mwdata),
        .pMemAck(ack), .pMemRData(rdata)
    );

    assign o_waddr_dummy = '0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_req = 0; m_we = 0; m_valid = 0; m_err = 0; m_busy = 0;
            m_addr = '0; m_wdata = '0; m_out = '0; m_wait = 0;
        end else begin
            logic was_req, was_idle;
            was_req  = m_req;
            was_idle = !m_busy;
            m_valid  = 0;
            m_err    = 0;
            if (was_req) begin
                if (ack) begin
                    if (!m_we) m_out = rdata;
                    m_valid = 1; m_req = 0; m_we = 0;
                end else begin
                    m_wait++;
`ifdef MEM_TIMEOUT_EN
                    if (m_wait == TO) begin m_err = 1; m_req = 0; m_we = 0; end
`endif
                end
            end else if (was_idle && req) begin
                if (addr[1:0] != 2'b00) m_err = 1;
                else begin
                    m_req = 1; m_we = we; m_addr = addr; m_wdata = wdata; m_wait = 0;
                end
            end
            m_busy = m_req | m_valid | m_err;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_out",    64'(o_out),    64'(m_out));
            chk("model_valid",  64'(o_valid),  64'(m_valid));
            chk("model_busy",   64'(o_busy),   64'(m_busy));
            chk("model_err",    64'(o_err),    64'(m_err));
            chk("model_mreq",   64'(o_mreq),   64'(m_req));
            chk("model_mwe",    64'(o_mwe),    64'(m_we));
            chk("model_maddr",  64'(o_maddr),  64'(m_addr));
            chk("model_mwdata", 64'(o_mwdata), 64'(m_wdata));
        end
    end

    initial begin
        int n;
        rst = 1; req = 0; we = 0; ack = 0; addr = '0; wdata = '0; rdata = '0;

        // T1 reset
        tick(); tick();
        rst = 0;
        cmp_en = 1'b1;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_mreq", 64'(o_mreq), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_out", 64'(o_out), 64'd0);

        // T2 read with two wait cycles
        req = 1; we = 0; addr = 32'h1000;
        tick();
        req = 0;
        chk("rd_mreq1", 64'(o_mreq), 64'd1);
        chk("rd_maddr", 64'(o_maddr), 64'h1000);
        tick();
        chk("rd_mreq2", 64'(o_mreq), 64'd1);
        tick();
        chk("rd_mreq3", 64'(o_mreq), 64'd1);
        ack = 1; rdata = 32'h12345678;
        tick();
        ack = 0;
        chk("rd_valid", 64'(o_valid), 64'd1);
        chk("rd_data", 64'(o_out), 64'h12345678);
        chk("rd_mreq_off", 64'(o_mreq), 64'd0);
        chk("rd_err", 64'(o_err), 64'd0);
        tick();
        chk("rd_valid_once", 64'(o_valid), 64'd0);
        chk("rd_idle", 64'(o_busy), 64'd0);

        // T3 write, immediate ack
        req = 1; we = 1; addr = 32'h2000; wdata = 32'h87654321;
        tick();
        req = 0; we = 0;
        chk("wr_mwe", 64'(o_mwe), 64'd1);
        chk("wr_mwdata", 64'(o_mwdata), 64'h87654321);
        ack = 1; rdata = 32'hFFFF0000;
        tick();
        ack = 0;
        chk("wr_valid", 64'(o_valid), 64'd1);
        chk("wr_out_kept", 64'(o_out), 64'h12345678);
        chk("wr_mwe_off", 64'(o_mwe), 64'd0);
        tick();

        // T4 misaligned
        req = 1; addr = 32'h3002;
        tick();
        req = 0;
        chk("mis_err", 64'(o_err), 64'd1);
        chk("mis_mreq", 64'(o_mreq), 64'd0);
        chk("mis_valid", 64'(o_valid), 64'd0);
        tick();
        chk("mis_err_once", 64'(o_err), 64'd0);

        // T5 request collision in REQ, ack collision in IDLE
        req = 1; addr = 32'h4000;
        tick();
        addr = 32'h5000;
        tick();
        req = 0;
        chk("col_addr_held", 64'(o_maddr), 64'h4000);
        ack = 1; rdata = 32'hCAFEF00D;
        tick();
        ack = 0;
        chk("col_valid", 64'(o_valid), 64'd1);
        tick();
        ack = 1; rdata = 32'hDEADBEEF;
        tick();
        ack = 0;
        chk("col_one_done", 64'(o_valid), 64'd0);
        chk("col_idle_ack", 64'(o_out), 64'hCAFEF00D);
        chk("col_idle_busy", 64'(o_busy), 64'd0);

        // T6 reset in REQ
        req = 1; we = 1; addr = 32'h6000; wdata = 32'h0BADF00D;
        tick();
        req = 0; we = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rreq_mreq", 64'(o_mreq), 64'd0);
        chk("rreq_mwe", 64'(o_mwe), 64'd0);
        chk("rreq_maddr", 64'(o_maddr), 64'd0);
        tick();
        chk("rreq_valid", 64'(o_valid), 64'd0);

`ifdef MEM_TIMEOUT_EN
        req = 1; addr = 32'h7000;
        tick();
        req = 0;
        n = 0;
        while (o_mreq && n < 40) begin
            n++;
            tick();
        end
        chk("to_req_cycles", 64'(n), 64'(TO));
        chk("to_err", 64'(o_err), 64'd1);
        tick();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            req   = ($urandom_range(0, 2) == 0);
            we    = $urandom_range(0, 1) == 1;
            addr  = $urandom;
            if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
            wdata = $urandom;
            rdata = $urandom;
            ack   = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst = 0; req = 0; ack = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
